// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the data-memory access path
package mem_pkg;

    typedef enum logic [2:0] {
        MODE_LB  = 3'b000,
        MODE_LH  = 3'b001,
        MODE_LW  = 3'b010,
        MODE_LBU = 3'b011,
        MODE_LHU = 3'b100,
        MODE_SB  = 3'b101,
        MODE_SH  = 3'b110,
        MODE_SW  = 3'b111
    } addr_mode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } mem_state_t;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // Store encodings occupy the top three codes.
    function automatic logic is_store(input addr_mode_t mode);
        return (mode == MODE_SB) || (mode == MODE_SH) || (mode == MODE_SW);
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - load lane select with sign/zero extension
import mem_pkg::*;

module mem_load_align (
    input  logic [31:0] rdata,
    input  logic [1:0]  lane,
    input  addr_mode_t  mode,
    output logic [31:0] result
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    // Pick the addressed byte/half and extend it according to the mode.
    always_comb begin
        byte_val = rdata[8*lane +: 8];
        half_val = lane[1] ? rdata[31:16] : rdata[15:0];
        case (mode)
            MODE_LB:  result = {{24{byte_val[7]}}, byte_val};
            MODE_LBU: result = {24'b0, byte_val};
            MODE_LH:  result = {{16{half_val[15]}}, half_val};
            MODE_LHU: result = {16'b0, half_val};
            default:  result = rdata;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - memory-stage load/store controller with stall handshake
import mem_pkg::*;

module data_mem_ctrl #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            AddrMode,
    input  logic [DATA_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  stall,
    output logic                  misalign_err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    mem_state_t state, state_next;
    addr_mode_t mode_in;
    addr_mode_t cap_mode;
    logic [1:0] cap_lane;

    logic req_any, mode_ok, align_ok, legal_req, illegal_req, accept;
    logic [3:0]            be_next;
    logic [DATA_WIDTH-1:0] wdata_next;
    logic [DATA_WIDTH-1:0] load_result;

    assign mode_in     = addr_mode_t'(AddrMode);
    assign req_any     = MemRead | MemWrite;
    // A write request wins over a simultaneous read, so the mode must be a store.
    assign mode_ok     = MemWrite ? is_store(mode_in) : !is_store(mode_in);
    assign legal_req   = req_any & mode_ok & align_ok;
    assign illegal_req = req_any & ~(mode_ok & align_ok);
    assign accept      = (state == IDLE) & legal_req;

    // Alignment rule: halves on even addresses, words on word boundaries.
    always_comb begin
        align_ok = 1'b1;
        case (mode_in)
            MODE_LH, MODE_LHU, MODE_SH: align_ok = ~addr[0];
            MODE_LW, MODE_SW:           align_ok = (addr[1:0] == 2'b00);
            default:                    align_ok = 1'b1;
        endcase
    end

    // Store lane replication and byte enables; loads fetch the whole word.
    always_comb begin
        be_next    = BE_WORD;
        wdata_next = '0;
        case (mode_in)
            MODE_SB: begin
                be_next    = BE_BYTE << addr[1:0];
                wdata_next = {4{WriteData[7:0]}};
            end
            MODE_SH: begin
                be_next    = BE_HALF << {addr[1], 1'b0};
                wdata_next = {2{WriteData[15:0]}};
            end
            MODE_SW: begin
                be_next    = BE_WORD;
                wdata_next = WriteData;
            end
            default: begin
                be_next    = BE_WORD;
                wdata_next = '0;
            end
        endcase
    end

    mem_load_align u_load_align (
        .rdata  (mem_rdata),
        .lane   (cap_lane),
        .mode   (cap_mode),
        .result (load_result)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state and stall; DONE releases the pipeline for one cycle.
    always_comb begin
        state_next = state;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                stall = legal_req;
                if (legal_req) state_next = ACCESS;
            end
            ACCESS: begin
                stall = 1'b1;
                if (mem_ack) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request capture, completion, load result and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_be       <= '0;
            mem_wdata    <= '0;
            cap_lane     <= '0;
            cap_mode     <= MODE_LB;
            ReadData     <= '0;
            misalign_err <= 1'b0;
        end else begin
            if (accept) begin
                mem_req   <= 1'b1;
                mem_we    <= MemWrite;
                mem_addr  <= {addr[DATA_WIDTH-1:2], 2'b00};
                mem_be    <= be_next;
                mem_wdata <= wdata_next;
                cap_lane  <= addr[1:0];
                cap_mode  <= mode_in;
            end
            if (state == ACCESS && mem_ack) begin
                mem_req <= 1'b0;
                if (!mem_we) ReadData <= load_result;
            end
            if (state == IDLE && illegal_req) misalign_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - self-checking bench for data_mem_ctrl
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemRead, MemWrite;
    logic [2:0]  AddrMode;
    logic [31:0] addr, WriteData, ReadData;
    logic        stall, misalign_err;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        mem_ack;

    int checks = 0;
    int passed = 0;
    logic [31:0] exp_rd = 0;
    logic        exp_err = 0;

    always #5 clk = ~clk;

    data_mem_ctrl #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
        .AddrMode(AddrMode), .addr(addr), .WriteData(WriteData),
        .ReadData(ReadData), .stall(stall), .misalign_err(misalign_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic int size_of(input int mode);
        if (mode == 0 || mode == 3 || mode == 5) return 1;
        if (mode == 1 || mode == 4 || mode == 6) return 2;
        return 4;
    endfunction

    function automatic bit legal(input bit rd, input bit wr, input int mode, input logic [31:0] a);
        if (!rd && !wr) return 0;
        if (wr && mode < 5) return 0;
        if (!wr && mode >= 5) return 0;
        return (a % size_of(mode)) == 0;
    endfunction

    function automatic logic [31:0] exp_load(input int mode, input int lane, input logic [31:0] rdv);
        logic [31:0] sh, v;
        sh = rdv >> (8 * lane);
        if (size_of(mode) == 1) begin
            v = sh & 32'hFF;
            if (mode == 0 && v >= 128) v = v + 32'hFFFFFF00;
        end else if (size_of(mode) == 2) begin
            v = sh & 32'hFFFF;
            if (mode == 1 && v >= 32768) v = v + 32'hFFFF0000;
        end else v = rdv;
        return v;
    endfunction

    function automatic logic [31:0] exp_be(input int mode, input int lane);
        int sz = size_of(mode);
        if (mode < 5 || sz == 4) return 32'hF;
        return ((1 << sz) - 1) << lane;
    endfunction

    function automatic logic [31:0] exp_wdata(input int mode, input logic [31:0] wd);
        int sz = size_of(mode);
        if (sz == 1) return (wd & 32'hFF) * 32'h01010101;
        if (sz == 2) return (wd & 32'hFFFF) * 32'h00010001;
        return wd;
    endfunction

    task automatic run_access(input bit rd, input bit wr, input int mode,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rdv, input int k, input string tag);
        bit lg;
        int lane;
        lg   = legal(rd, wr, mode, a);
        lane = a % 4;
        @(negedge clk);
        MemRead = rd; MemWrite = wr; AddrMode = mode[2:0]; addr = a;
        WriteData = wd; mem_rdata = rdv; mem_ack = 0;
        #1 check({tag, ".stall_req"}, stall, lg);
        if (!lg) begin
            exp_err = 1;
            @(negedge clk);
            MemRead = 0; MemWrite = 0;
            #1;
            check({tag, ".no_req"}, mem_req, 0);
            check({tag, ".no_stall"}, stall, 0);
            check({tag, ".err"}, misalign_err, exp_err);
            check({tag, ".rd_keep"}, ReadData, exp_rd);
            return;
        end
        for (int j = 1; j <= k; j++) begin
            @(negedge clk);
            check({tag, ".req"}, mem_req, 1);
            check({tag, ".stall"}, stall, 1);
            if (j == 1) begin
                check({tag, ".we"}, mem_we, wr);
                check({tag, ".addr"}, mem_addr, a - lane);
                check({tag, ".be"}, mem_be, exp_be(mode, lane));
                if (wr) check({tag, ".wdata"}, mem_wdata, exp_wdata(mode, wd));
            end
            mem_ack = (j == k);
        end
        @(negedge clk);
        mem_ack = 0;
        if (!wr) exp_rd = exp_load(mode, lane, rdv);
        #1;
        check({tag, ".done_stall"}, stall, 0);
        check({tag, ".done_req"}, mem_req, 0);
        check({tag, ".rdata"}, ReadData, exp_rd);
        check({tag, ".err"}, misalign_err, exp_err);
        MemRead = 0; MemWrite = 0;
    endtask

    initial begin
        rst_n = 0; MemRead = 0; MemWrite = 0; AddrMode = 0; addr = 0;
        WriteData = 0; mem_ack = 0; mem_rdata = 0;
        repeat (2) @(negedge clk);
        check("rst.ReadData", ReadData, 0);
        check("rst.err", misalign_err, 0);
        check("rst.req", mem_req, 0);
        check("rst.we", mem_we, 0);
        check("rst.be", mem_be, 0);
        check("rst.addr", mem_addr, 0);
        check("rst.wdata", mem_wdata, 0);
        check("rst.stall", stall, 0);
        rst_n = 1;

        run_access(0, 1, 7, 32'h100, 32'hDEADBEEF, 32'h0, 2, "sw");
        run_access(1, 0, 0, 32'h103, 32'h0, 32'h80FF1234, 1, "lb");
        check("lb.value", ReadData, 32'hFFFFFF80);
        run_access(1, 0, 3, 32'h103, 32'h0, 32'h80FF1234, 1, "lbu");
        check("lbu.value", ReadData, 32'h00000080);
        run_access(1, 0, 1, 32'h102, 32'h0, 32'h80FF1234, 2, "lh");
        check("lh.value", ReadData, 32'hFFFF80FF);
        run_access(1, 0, 4, 32'h100, 32'h0, 32'h80FF1234, 3, "lhu");
        check("lhu.value", ReadData, 32'h00001234);
        run_access(0, 1, 5, 32'h101, 32'h000000AB, 32'h0, 1, "sb");
        run_access(0, 1, 6, 32'h102, 32'h0000CAFE, 32'h0, 1, "sh");

        run_access(1, 0, 2, 32'h102, 32'h0, 32'h12345678, 1, "lw_mis");
        run_access(0, 1, 6, 32'h103, 32'h1111, 32'h0, 1, "sh_mis");
        mem_ack = 1;
        repeat (10) @(negedge clk);
        mem_ack = 0;
        check("err_sticky", misalign_err, 1);
        check("idle_ack_no_req", mem_req, 0);
        run_access(1, 0, 2, 32'h104, 32'h0, 32'hA5A55A5A, 1, "lw_after");

        for (int i = 0; i < 40; i++) begin
            int mode, sz, k;
            bit st, rd, wr;
            logic [31:0] a;
            mode = $urandom_range(0, 7);
            sz   = size_of(mode);
            st   = (mode >= 5);
            if ($urandom_range(0, 7) == 0) begin rd = st; wr = !st; end
            else begin rd = !st; wr = st; end
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a - (a % sz);
            k = $urandom_range(1, 4);
            run_access(rd, wr, mode, a, $urandom, $urandom, k, "rand");
        end

        @(negedge clk);
        MemRead = 1; AddrMode = 3'b010; addr = 32'h200;
        repeat (2) @(negedge clk);
        check("rst_mid.req_before", mem_req, 1);
        rst_n = 0; MemRead = 0;
        #1;
        check("rst_mid.req", mem_req, 0);
        check("rst_mid.stall", stall, 0);
        check("rst_mid.ReadData", ReadData, 0);
        check("rst_mid.err", misalign_err, 0);
        exp_rd = 0; exp_err = 0;
        @(negedge clk);
        rst_n = 1;
        run_access(1, 0, 2, 32'h200, 32'h0, 32'h0BADF00D, 1, "lw_fresh");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Memory-stage access controller: the responder to the decoder's MemRead/MemWrite/AddrMode/stall signals. Converts a byte/half/word load or store into a word-aligned, byte-enabled request on a variable-latency backing-memory handshake. Aligns and extends load data, and drives `stall` to freeze the pipeline until the access completes. Sits between the EX/MEM pipeline register and data memory.

## Interface
Parameters:
- DATA_WIDTH, 32, data and address width; only 32 is supported.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- MemRead  in  1  load request, driven from the EX/MEM register.
- MemWrite  in  1  store request, driven from the EX/MEM register.
- AddrMode  in  3  access mode: 000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, 101 SB, 110 SH, 111 SW.
- addr  in  32  byte address (ALU result).
- WriteData  in  32  store data; the low bytes are used for SB/SH.
- ReadData  out  32  aligned, extended load result; valid in DONE.
- stall  out  1  pipeline freeze.
- misalign_err  out  1  sticky illegal/misaligned-access flag.
- mem_req  out  1  backing-memory request.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word address: addr with [1:0] forced to 00.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_ack  in  1  request completed; for reads, mem_rdata is valid in the same cycle.
- mem_rdata  in  32  read word.

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE:
  - A legal request (MemRead or MemWrite) sets `stall`=1 combinationally, captures addr, mode and data, and transitions to ACCESS.
  - If both MemRead and MemWrite are set, the write wins.
- ACCESS:
  - mem_req=1, with mem_we/mem_addr/mem_be/mem_wdata held stable until mem_ack.
  - On mem_ack: a read registers the extended data into ReadData, and the FSM transitions to DONE.
- DONE:
  - `stall`=0 for exactly one cycle so the instruction advances.
  - Inputs are ignored.
  - Transitions to IDLE.
- Store lanes:
  - SB: be = 0001 << addr[1:0], wdata = the byte replicated ×4.
  - SH: be = 0011 << (2·addr[1]), wdata = the half replicated ×2.
  - SW: be = 1111.
- Load extraction:
  - Byte lane = addr[1:0]; half = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - For loads, mem_be = 1111.
- Illegal accesses, detected in IDLE:
  - Half access with addr[0]=1.
  - Word access with addr[1:0]≠00.
  - MemRead with AddrMode ≥101.
  - MemWrite with AddrMode ≤100.
- Response to an illegal access:
  - misalign_err is set and stays set until reset.
  - No mem_req is issued, `stall` stays 0, and ReadData is unchanged.
- mem_ack outside ACCESS is ignored.

## Timing
- Reset values: state IDLE, ReadData 0, misalign_err 0, mem_req 0, mem_we 0, mem_be 0, mem_addr 0, mem_wdata 0.
- `stall` = (state==ACCESS) | (state==IDLE & legal request). It is a function of registered inputs and state only, so there is no path from stall back into MemRead/MemWrite.
- Request seen in IDLE at cycle T: ACCESS starts at T+1, with mem_req high from T+1.
- mem_ack at T+k (k≥1): DONE at T+k+1, ReadData valid at T+k+1.
  - `stall` is high for cycles T..T+k.
  - Minimum total: 3 cycles, with stall high for 2.
- A new request can be accepted in the cycle after DONE.
- Reset asserted mid-ACCESS:
  - Immediate return to IDLE with mem_req=0.
  - The outstanding access is abandoned; memory-side cancellation is the integrator's concern.
- Addresses wrap modulo 2^32; there is no bounds check.

## Structure
- Package `mem_pkg`:
  - `addr_mode_t` enum, with the 8 AddrMode encodings above.
  - `mem_state_t` enum {IDLE, ACCESS, DONE}.
  - Byte-enable constants BE_BYTE=4'b0001, BE_HALF=4'b0011, BE_WORD=4'b1111.
- Sub-module `mem_load_align`: combinational lane select plus sign/zero extension (mem_rdata, addr[1:0], mode → 32-bit result). Instantiated once. Reused by any future cache.
- Top level holds the FSM, capture registers, store lane and byte-enable generation, and the illegal-access check.

## Test plan
- SW, addr 0x100, WriteData 0xDEADBEEF, mem_ack in the 2nd ACCESS cycle → mem_addr 0x100, mem_be 1111, mem_wdata 0xDEADBEEF, mem_we 1, stall high 3 cycles then low 1 cycle (DONE).
- LB, addr 0x103, mem_rdata 0x80FF1234 → ReadData 0xFFFFFF80. LBU with the same stimulus → 0x00000080.
- LH, addr 0x102, mem_rdata 0x80FF1234 → ReadData 0xFFFF80FF. LHU at 0x100 → 0x00001234. mem_addr 0x100 in both cases.
- SB, addr 0x101, WriteData 0x000000AB → mem_be 0010, mem_wdata 0xABABABAB. SH at 0x102 with 0x0000CAFE → mem_be 1100, mem_wdata 0xCAFECAFE.
- LW at 0x102, then SH at 0x103 → no mem_req, stall stays 0, misalign_err=1 and still 1 ten cycles later; a following legal LW completes normally.
- rst_n low for 1 cycle during ACCESS, with mem_ack never asserted → asynchronous return to IDLE, mem_req/stall/ReadData/misalign_err all 0 before the next edge; a fresh LW after release completes in 3 cycles.
